card_grid_renderer: RTL and testbench

Parametrised VGA card-field renderer for the memory-card game, generalising the single-card sprite to a COLS x ROWS grid.
- Holds per-card state: face-down, face-up or removed.
- Runs a frame-paced flip animation on one card at a time, driven by a ready/valid command port.
- Emits a registered pixel colour and card-hit flag for the current HCount/VCount.
- Sits between the game controller (commands, selection cursor) and the VGA colour mux.

---
 rtl/card_grid_renderer_if.sv | 9 +
 rtl/card_grid_renderer.sv | 128 ++++++++++++
 tb/tb_card_grid_renderer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/card_grid_renderer_if.sv
// card_grid_renderer_if: ready/valid command channel into the card grid renderer.
interface card_grid_renderer_if #(parameter int PW = 4);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [PW-1:0] cmd_pos;
    modport master(output cmd_valid, cmd_op, cmd_pos, input cmd_ready);
    modport slave(input cmd_valid, cmd_op, cmd_pos, output cmd_ready);
endinterface

// File: rtl/card_grid_renderer.sv
// card_grid_renderer: COLS x ROWS memory-card field with per-card state,
// frame-paced flip animation and a one-cycle registered pixel path.
module card_grid_renderer #(
    parameter int COLS        = 4,
    parameter int ROWS        = 4,
    parameter int CARD_W      = 64,
    parameter int CARD_H      = 96,
    parameter int GAP         = 8,
    parameter int X0          = 100,
    parameter int Y0          = 40,
    parameter int FLIP_FRAMES = 8,
    parameter logic [2:0] BACK_RGB = 3'b001,
    localparam int N  = COLS * ROWS,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    HCount,
    input  logic [9:0]    VCount,
    input  logic          frame_tick,
    card_grid_renderer_if.slave cmd,
    input  logic [PW-1:0] sel_pos,
    output logic          busy,
    output logic [N-1:0]  face_up,
    output logic          cardon,
    output logic [2:0]    rgb
);
    localparam int H    = FLIP_FRAMES / 2;
    localparam int STEP = CARD_W / FLIP_FRAMES;
    localparam int AW   = $clog2(FLIP_FRAMES + 1);

    typedef enum logic {IDLE, ANIM} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [N-1:0]    face_up_q, face_up_d;
    logic [N-1:0]    removed_q, removed_d;
    logic            cardon_q, cardon_d;
    logic [2:0]      rgb_q, rgb_d;
    logic            eff;
    int              k_anim, hx, vy, l, r, t, b;

    assign busy          = state_q == ANIM;
    assign cmd.cmd_ready = state_q == IDLE;
    assign face_up       = face_up_q;
    assign cardon        = cardon_q;
    assign rgb           = rgb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            pos_q     <= '0;
            face_up_q <= '0;
            removed_q <= '0;
            cardon_q  <= 1'b0;
            rgb_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            pos_q     <= pos_d;
            face_up_q <= face_up_d;
            removed_q <= removed_d;
            cardon_q  <= cardon_d;
            rgb_q     <= rgb_d;
        end
    end

    // A command only animates when it would actually change the card's face.
    assign eff = cmd.cmd_op == 2'b00 ||
                 (cmd.cmd_op == 2'b01 && !face_up_q[cmd.cmd_pos]) ||
                 (cmd.cmd_op == 2'b10 && face_up_q[cmd.cmd_pos]);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        pos_d     = pos_q;
        face_up_d = face_up_q;
        removed_d = removed_q;
        if (state_q == IDLE) begin
            if (cmd.cmd_valid && int'(cmd.cmd_pos) < N && !removed_q[cmd.cmd_pos]) begin
                if (cmd.cmd_op == 2'b11) begin
                    removed_d[cmd.cmd_pos] = 1'b1;
                    face_up_d[cmd.cmd_pos] = 1'b0;
                end else if (eff) begin
                    pos_d   = cmd.cmd_pos;
                    a_d     = '0;
                    state_d = ANIM;
                end
            end
        end else if (frame_tick) begin
            a_d = a_q + 1'b1;
            if (a_q == AW'(H - 1))
                face_up_d[pos_q] = ~face_up_q[pos_q];
            if (a_q == AW'(FLIP_FRAMES - 1)) begin
                a_d     = '0;
                state_d = IDLE;
            end
        end
    end

    assign k_anim = state_q == ANIM ? (int'(a_q) <= H ? int'(a_q) : FLIP_FRAMES - int'(a_q)) : 0;
    assign hx     = int'(HCount);
    assign vy     = int'(VCount);

    // Cards never overlap, so at most one iteration claims the pixel.
    always_comb begin
        cardon_d = 1'b0;
        rgb_d    = 3'b000;
        l = 0;
        r = 0;
        t = 0;
        b = 0;
        for (int c = 0; c < N; c++) begin
            l = X0 + (c % COLS) * (CARD_W + GAP) + (c == int'(pos_q) ? k_anim : 0) * STEP;
            r = X0 + (c % COLS) * (CARD_W + GAP) + CARD_W - 1 - (c == int'(pos_q) ? k_anim : 0) * STEP;
            t = Y0 + (c / COLS) * (CARD_H + GAP);
            b = t + CARD_H - 1;
            if (!removed_q[c] && hx >= l && hx <= r && vy >= t && vy <= b) begin
                cardon_d = 1'b1;
                rgb_d = (hx == l || hx == r || vy == t || vy == b) ?
                        (c == int'(sel_pos) ? 3'b110 : 3'b111) :
                        face_up_q[c] ? 3'(((c >> 1) % 5) + 2) : BACK_RGB;
            end
        end
    end
endmodule

// File: tb/tb_card_grid_renderer.sv
// tb_card_grid_renderer: directed and randomized checks of the card grid renderer
// against a geometric reference model of the card field.
module tb_card_grid_renderer;
    localparam int COLS = 4, ROWS = 4, N = 16, CARD_W = 64, CARD_H = 96, GAP = 8;
    localparam int X0 = 100, Y0 = 40, FF = 8, H = 4, STEP = 8;

    logic       clk = 0;
    logic       reset = 1;
    logic [9:0] HCount = 0, VCount = 0;
    logic       frame_tick = 0;
    logic [3:0] sel_pos = 1;
    logic       busy, cardon;
    logic [15:0] face_up;
    logic [2:0] rgb;

    card_grid_renderer_if #(.PW(4)) cif();

    card_grid_renderer dut (
        .clk(clk), .reset(reset), .HCount(HCount), .VCount(VCount),
        .frame_tick(frame_tick), .cmd(cif), .sel_pos(sel_pos),
        .busy(busy), .face_up(face_up), .cardon(cardon), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [15:0] fu_m, rm_m;
    bit anim_m;
    int card_m, cnt_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        fu_m = '0; rm_m = '0; anim_m = 0; card_m = 0; cnt_m = 0;
    endtask

    task automatic model_cmd(input int op, input int pos);
        if (pos >= N || rm_m[pos]) return;
        if (op == 3) begin
            rm_m[pos] = 1; fu_m[pos] = 0;
        end else if (op == 0 || (op == 1 && !fu_m[pos]) || (op == 2 && fu_m[pos])) begin
            anim_m = 1; card_m = pos; cnt_m = 0;
        end
    endtask

    function automatic logic [3:0] model_px(input int h, input int v, input int sel);
        int dx, dy, col, row, ox, oy, c, k, ins;
        if (h < X0 || v < Y0) return 4'b0;
        dx = h - X0; dy = v - Y0;
        col = dx / (CARD_W + GAP); ox = dx % (CARD_W + GAP);
        row = dy / (CARD_H + GAP); oy = dy % (CARD_H + GAP);
        if (col >= COLS || row >= ROWS || ox >= CARD_W || oy >= CARD_H) return 4'b0;
        c = row * COLS + col;
        if (rm_m[c]) return 4'b0;
        k = (anim_m && c == card_m) ? (cnt_m <= H ? cnt_m : FF - cnt_m) : 0;
        ins = k * STEP;
        if (ox < ins || ox >= CARD_W - ins) return 4'b0;
        if (ox == ins || ox == CARD_W - 1 - ins || oy == 0 || oy == CARD_H - 1)
            return {1'b1, (c == sel) ? 3'b110 : 3'b111};
        return {1'b1, fu_m[c] ? 3'((c / 2) % 5 + 2) : 3'b001};
    endfunction

    task automatic frame();
        frame_tick = 1;
        tick();
        frame_tick = 0;
        if (anim_m) begin
            cnt_m++;
            if (cnt_m == H) fu_m[card_m] = ~fu_m[card_m];
            if (cnt_m == FF) begin anim_m = 0; cnt_m = 0; end
        end
    endtask

    task automatic probe(input int h, input int v);
        HCount = 10'(h); VCount = 10'(v);
        tick();
    endtask

    task automatic send(input int op, input int pos);
        bit done = 0;
        cif.cmd_valid = 1; cif.cmd_op = 2'(op); cif.cmd_pos = 4'(pos);
        for (int i = 0; i < 50 && !done; i++) begin
            done = cif.cmd_ready;
            tick();
        end
        cif.cmd_valid = 0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL send_timeout: cmd_ready never seen for op %0d pos %0d", op, pos);
        end else model_cmd(op, pos);
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick();
        n_cmp++;
        if ({cardon, rgb, busy, cif.cmd_ready, face_up} !== {1'b0, 3'b0, 1'b0, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got cardon=%b rgb=%b busy=%b ready=%b face_up=%h want 0 0 0 1 0",
                     cardon, rgb, busy, cif.cmd_ready, face_up);
        end
        reset = 0;
        model_reset();
    endtask

    task automatic test_static();
        int pts[3][2] = '{'{135, 75}, '{100, 75}, '{166, 75}};
        logic [3:0] want[3] = '{4'b1001, 4'b1111, 4'b0000};
        sel_pos = 1;
        for (int i = 0; i < 3; i++) begin
            probe(pts[i][0], pts[i][1]);
            n_cmp++;
            if ({cardon, rgb} !== want[i] || want[i] !== model_px(pts[i][0], pts[i][1], 1)) begin
                n_bad++;
                $display("FAIL static_px(%0d,%0d): got %b want %b", pts[i][0], pts[i][1], {cardon, rgb}, want[i]);
            end
        end
        sel_pos = 0;
        probe(100, 75);
        n_cmp++;
        if (rgb !== 3'b110) begin n_bad++; $display("FAIL sel_border: got %b want 110", rgb); end
        sel_pos = 1;
        probe(100, 75);
        n_cmp++;
        if (rgb !== 3'b111) begin n_bad++; $display("FAIL unsel_border: got %b want 111", rgb); end
    endtask

    task automatic test_flip();
        send(0, 0);
        n_cmp++;
        if ({cif.cmd_ready, busy} !== 2'b01) begin
            n_bad++; $display("FAIL flip_start: ready=%b busy=%b want 0 1", cif.cmd_ready, busy);
        end
        frame(); frame();
        probe(110, 75);
        n_cmp++;
        if (cardon !== 1'b0) begin n_bad++; $display("FAIL inset_off: cardon=%b want 0", cardon); end
        probe(116, 75);
        n_cmp++;
        if ({cardon, rgb} !== 4'b1111) begin n_bad++; $display("FAIL inset_border: got %b want 1111", {cardon, rgb}); end
        frame(); frame();
        n_cmp++;
        if (face_up !== 16'h0001) begin n_bad++; $display("FAIL mid_toggle: face_up=%h want 0001", face_up); end
        for (int i = 0; i < 4; i++) frame();
        n_cmp++;
        if ({busy, cif.cmd_ready} !== 2'b01) begin
            n_bad++; $display("FAIL flip_end: busy=%b ready=%b want 0 1", busy, cif.cmd_ready);
        end
        probe(135, 75);
        n_cmp++;
        if (rgb !== 3'b010) begin n_bad++; $display("FAIL face_colour0: got %b want 010", rgb); end
    endtask

    task automatic test_back_to_back();
        send(0, 0);
        cif.cmd_valid = 1; cif.cmd_op = 2'b01; cif.cmd_pos = 4'd5;
        for (int i = 0; i < 8; i++) frame();
        n_cmp++;
        if ({busy, cif.cmd_ready} !== 2'b01) begin
            n_bad++; $display("FAIL held_release: busy=%b ready=%b want 0 1", busy, cif.cmd_ready);
        end
        tick();
        cif.cmd_valid = 0;
        model_cmd(1, 5);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL held_accept: busy=%b want 1", busy); end
        for (int i = 0; i < 8; i++) frame();
        n_cmp++;
        if (face_up !== fu_m || fu_m !== 16'h0020) begin
            n_bad++; $display("FAIL show5: face_up=%h want 0020", face_up);
        end
        probe(200, 190);
        n_cmp++;
        if (rgb !== 3'b100) begin n_bad++; $display("FAIL face_colour5: got %b want 100", rgb); end
        send(1, 5);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL redundant_show: busy=%b want 0", busy); end
    endtask

    task automatic test_remove();
        send(3, 5);
        tick();
        probe(200, 190);
        n_cmp++;
        if ({cardon, rgb} !== 4'b0000) begin n_bad++; $display("FAIL removed_px: got %b want 0000", {cardon, rgb}); end
        send(0, 5);
        n_cmp++;
        if (busy !== 1'b0 || face_up !== fu_m) begin
            n_bad++; $display("FAIL flip_removed: busy=%b face_up=%h want 0 %h", busy, face_up, fu_m);
        end
    endtask

    task automatic test_reset_mid();
        send(0, 3);
        for (int i = 0; i < 5; i++) frame();
        HCount = 10'd320; VCount = 10'd75;
        reset = 1;
        tick();
        n_cmp++;
        if ({busy, cardon, face_up} !== 18'b0) begin
            n_bad++; $display("FAIL reset_mid: busy=%b cardon=%b face_up=%h want all 0", busy, cardon, face_up);
        end
        reset = 0;
        model_reset();
        probe(316, 75);
        n_cmp++;
        if ({cardon, rgb} !== 4'b1111) begin n_bad++; $display("FAIL card3_edge: got %b want 1111", {cardon, rgb}); end
        probe(320, 75);
        n_cmp++;
        if ({cardon, rgb} !== 4'b1001) begin n_bad++; $display("FAIL card3_back: got %b want 1001", {cardon, rgb}); end
    endtask

    task automatic test_random();
        logic [3:0] exp;
        int h, v, r;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0 && !anim_m) begin
                send($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2), $urandom_range(0, N - 1));
                n_cmp++;
                if (busy !== anim_m) begin n_bad++; $display("FAIL rnd_busy: got %b want %b", busy, anim_m); end
            end else if (r <= 2) begin
                frame();
                n_cmp++;
                if (face_up !== fu_m) begin n_bad++; $display("FAIL rnd_face: got %h want %h", face_up, fu_m); end
            end else begin
                sel_pos = 4'($urandom_range(0, N - 1));
                h = $urandom_range(90, 390);
                v = $urandom_range(30, 460);
                probe(h, v);
                exp = model_px(h, v, int'(sel_pos));
                n_cmp++;
                if ({cardon, rgb} !== exp) begin
                    n_bad++; $display("FAIL rnd_px(%0d,%0d): got %b want %b", h, v, {cardon, rgb}, exp);
                end
            end
        end
    endtask

    initial begin
        cif.cmd_valid = 0; cif.cmd_op = 0; cif.cmd_pos = 0;
        model_reset();
        test_reset();
        test_static();
        test_flip();
        test_back_to_back();
        test_remove();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
